// File: rtl/self_purging_voter_if.sv
// Bus bundle for the self-purging majority voter.
// The master drives replica samples; the slave returns the voted result.
interface self_purging_voter_if #(
    parameter int adder_width = 32,
    parameter int N           = 5
);
    logic                     J;
    logic                     in_valid;
    logic [N*adder_width-1:0] mod_sum;
    logic [N-1:0]             mod_cout;

    logic                     out_valid;
    logic [adder_width-1:0]   sum;
    logic                     cout;
    logic [N-1:0]             enable;
    logic [3:0]               active_count;
    logic                     fault_flag;
    logic                     tie_err;

    modport master (
        output J,
        output in_valid,
        output mod_sum,
        output mod_cout,
        input  out_valid,
        input  sum,
        input  cout,
        input  enable,
        input  active_count,
        input  fault_flag,
        input  tie_err
    );

    modport slave (
        input  J,
        input  in_valid,
        input  mod_sum,
        input  mod_cout,
        output out_valid,
        output sum,
        output cout,
        output enable,
        output active_count,
        output fault_flag,
        output tie_err
    );
endinterface

// File: rtl/self_purging_voter.sv
// N-replica bitwise majority voter over {cout, sum} words.
// Replicas that keep disagreeing with the vote are purged from the mask.
module self_purging_voter #(
    parameter int adder_width = 32,
    parameter int N           = 5,
    parameter int LIMIT       = 2
) (
    input logic                 clk,
    input logic                 rst,
    self_purging_voter_if.slave bus
);
    localparam int W = adder_width + 1;
    localparam logic [3:0] LIM = 4'(LIMIT);
    localparam logic [3:0] N_CNT = 4'(N);

    logic [W-1:0]         word [N];
    logic [W-1:0]         voted;
    logic [W-1:0]         tie_bits;
    logic [4:0]           ones;
    logic [4:0]           zeros;
    logic [N-1:0]         mismatch;
    logic [N-1:0]         hit;
    logic [N-1:0]         kept;
    logic                 suppress;

    logic                 out_valid_q, out_valid_d;
    logic [adder_width-1:0] sum_q, sum_d;
    logic                 cout_q, cout_d;
    logic [N-1:0]         enable_q, enable_d;
    logic [3:0]           active_count_q, active_count_d;
    logic [N-1:0][3:0]    cnt_q, cnt_d;
    logic                 fault_flag_q, fault_flag_d;
    logic                 tie_err_q, tie_err_d;

    function automatic logic [3:0] popcnt(input logic [N-1:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    // Unpack each replica into one {cout, sum} word
    always_comb begin
        for (int i = 0; i < N; i++) begin
            word[i] = {bus.mod_cout[i],
                       bus.mod_sum[i*adder_width +: adder_width]};
        end
    end

    // Per-bit majority over active replicas; exact ties vote 0
    always_comb begin
        voted    = '0;
        tie_bits = '0;
        ones     = '0;
        zeros    = '0;
        for (int b = 0; b < W; b++) begin
            ones  = '0;
            zeros = '0;
            for (int i = 0; i < N; i++) begin
                if (enable_q[i]) begin
                    if (word[i][b]) begin
                        ones = ones + 5'd1;
                    end else begin
                        zeros = zeros + 5'd1;
                    end
                end
            end
            if ({ones, 1'b0} > {2'b00, active_count_q}) begin
                voted[b] = 1'b1;
            end else if ({zeros, 1'b0} <= {2'b00, active_count_q}) begin
                tie_bits[b] = 1'b1;
            end
        end
    end

    // Active replicas disagreeing with the vote on any non-tie bit
    always_comb begin
        for (int i = 0; i < N; i++) begin
            mismatch[i] = enable_q[i] &&
                          (|((word[i] ^ voted) & ~tie_bits));
        end
    end

    // Replicas reaching LIMIT now; purge is vetoed if fewer than 2 remain
    always_comb begin
        hit = '0;
        for (int i = 0; i < N; i++) begin
            hit[i] = mismatch[i] &&
                     (({1'b0, cnt_q[i]} + 5'd1) >= {1'b0, LIM});
        end
        kept     = enable_q & ~hit;
        suppress = (hit != '0) && (popcnt(kept) < 4'd2);
    end

    // Next-state for outputs, mask, counters and sticky flags
    always_comb begin
        out_valid_d  = 1'b0;
        sum_d        = sum_q;
        cout_d       = cout_q;
        enable_d     = enable_q;
        cnt_d        = cnt_q;
        fault_flag_d = fault_flag_q;
        tie_err_d    = tie_err_q;
        if (bus.J) begin
            enable_d     = '1;
            cnt_d        = '0;
            fault_flag_d = 1'b0;
            tie_err_d    = 1'b0;
        end else if (bus.in_valid) begin
            out_valid_d = 1'b1;
            sum_d       = voted[adder_width-1:0];
            cout_d      = voted[W-1];
            if (|tie_bits) begin
                tie_err_d = 1'b1;
            end
            for (int i = 0; i < N; i++) begin
                if (!enable_q[i]) begin
                    cnt_d[i] = cnt_q[i];
                end else if (!mismatch[i]) begin
                    cnt_d[i] = '0;
                end else if (hit[i]) begin
                    cnt_d[i] = suppress ? LIM : 4'd0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                end
            end
            if ((hit != '0) && !suppress) begin
                enable_d     = kept;
                fault_flag_d = 1'b1;
            end
        end
        active_count_d = popcnt(enable_d);
    end

    // State registers with synchronous reset taking priority
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q    <= 1'b0;
            sum_q          <= '0;
            cout_q         <= 1'b0;
            enable_q       <= '1;
            active_count_q <= N_CNT;
            cnt_q          <= '0;
            fault_flag_q   <= 1'b0;
            tie_err_q      <= 1'b0;
        end else begin
            out_valid_q    <= out_valid_d;
            sum_q          <= sum_d;
            cout_q         <= cout_d;
            enable_q       <= enable_d;
            active_count_q <= active_count_d;
            cnt_q          <= cnt_d;
            fault_flag_q   <= fault_flag_d;
            tie_err_q      <= tie_err_d;
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.sum          = sum_q;
    assign bus.cout         = cout_q;
    assign bus.enable       = enable_q;
    assign bus.active_count = active_count_q;
    assign bus.fault_flag   = fault_flag_q;
    assign bus.tie_err      = tie_err_q;
endmodule

// File: tb/tb_self_purging_voter.sv
// Scoreboard bench for the self-purging voter, N=5, 32-bit, LIMIT=2.
// Directed vectors push hand-computed results; a monitor pops them.
module tb_self_purging_voter;
    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic [4:0]  en;
        logic [3:0]  ac;
        logic        f;
        logic        t;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    exp_t sb[$];

    self_purging_voter_if #(.adder_width(32), .N(5)) bus ();

    self_purging_voter #(
        .adder_width(32),
        .N(5),
        .LIMIT(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [159:0] pack5(input logic [31:0] a,
        input logic [31:0] b, input logic [31:0] c,
        input logic [31:0] d, input logic [31:0] e);
        return {e, d, c, b, a};
    endfunction

    function automatic exp_t mk(input logic [31:0] s, input logic c,
        input logic [4:0] en, input logic [3:0] ac,
        input logic f, input logic t);
        exp_t x;
        x.sum  = s;
        x.cout = c;
        x.en   = en;
        x.ac   = ac;
        x.f    = f;
        x.t    = t;
        return x;
    endfunction

    task automatic step(input logic [159:0] s, input logic [4:0] c,
                        input exp_t e);
        @(negedge clk);
        bus.J        = 1'b0;
        bus.in_valid = 1'b1;
        bus.mod_sum  = s;
        bus.mod_cout = c;
        sb.push_back(e);
    endtask

    task automatic do_j(input logic [31:0] hold_sum);
        @(negedge clk);
        bus.J        = 1'b1;
        bus.in_valid = 1'b1;
        bus.mod_sum  = pack5(9, 9, 9, 9, 9);
        bus.mod_cout = 5'b11111;
        @(negedge clk);
        bus.J        = 1'b0;
        bus.in_valid = 1'b0;
        chk("j_out_valid", bus.out_valid, 0);
        chk("j_enable", bus.enable, 5'h1F);
        chk("j_active_count", bus.active_count, 5);
        chk("j_fault_flag", bus.fault_flag, 0);
        chk("j_tie_err", bus.tie_err, 0);
        chk("j_sum_hold", bus.sum, hold_sum);
    endtask

    // Monitor: compare every presented result against the queue head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_out: got sum %0h expected none",
                             bus.sum);
                end else begin
                    e = sb.pop_front();
                    chk("sum", bus.sum, e.sum);
                    chk("cout", bus.cout, e.cout);
                    chk("enable", bus.enable, e.en);
                    chk("active_count", bus.active_count, e.ac);
                    chk("fault_flag", bus.fault_flag, e.f);
                    chk("tie_err", bus.tie_err, e.t);
                end
            end
        end
    end

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        rst          = 1'b1;
        bus.J        = 1'b0;
        bus.in_valid = 1'b0;
        bus.mod_sum  = '0;
        bus.mod_cout = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_sum", bus.sum, 0);
        chk("rst_cout", bus.cout, 0);
        chk("rst_enable", bus.enable, 5'h1F);
        chk("rst_active_count", bus.active_count, 5);
        chk("rst_fault_flag", bus.fault_flag, 0);
        chk("rst_tie_err", bus.tie_err, 0);
        rst = 1'b0;

        step(pack5(10, 10, 10, 10, 10), 5'b0, mk(10, 0, 5'h1F, 5, 0, 0));
        step(pack5(10, 10, 11, 10, 10), 5'b0, mk(10, 0, 5'h1F, 5, 0, 0));
        step(pack5(10, 10, 10, 10, 10), 5'b0, mk(10, 0, 5'h1F, 5, 0, 0));
        step(pack5(10, 10, 11, 10, 10), 5'b0, mk(10, 0, 5'h1F, 5, 0, 0));
        step(pack5(10, 10, 10, 10, 10), 5'b0, mk(10, 0, 5'h1F, 5, 0, 0));
        step(pack5(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                   32'hFFFFFFFF, 32'hFFFFFFFF), 5'b00111,
             mk(32'hFFFFFFFF, 1, 5'h1F, 5, 0, 0));
        step(pack5(10, 10, 10, 10, 10), 5'b0, mk(10, 0, 5'h1F, 5, 0, 0));
        step(pack5(10, 10, 11, 10, 10), 5'b0, mk(10, 0, 5'h1F, 5, 0, 0));
        step(pack5(10, 10, 11, 10, 10), 5'b0, mk(10, 0, 5'h1B, 4, 1, 0));
        step(pack5(20, 20, 999, 20, 20), 5'b0, mk(20, 0, 5'h1B, 4, 1, 0));
        step(pack5(5, 5, 5, 7, 5), 5'b0, mk(5, 0, 5'h1B, 4, 1, 0));
        step(pack5(5, 5, 5, 7, 5), 5'b0, mk(5, 0, 5'h13, 3, 1, 0));
        step(pack5(6, 6, 6, 6, 100), 5'b0, mk(6, 0, 5'h13, 3, 1, 0));
        step(pack5(6, 6, 6, 6, 100), 5'b0, mk(6, 0, 5'h03, 2, 1, 0));
        step(pack5(48, 49, 0, 0, 0), 5'b0, mk(48, 0, 5'h03, 2, 1, 1));
        step(pack5(50, 50, 77, 77, 77), 5'b11100,
             mk(50, 0, 5'h03, 2, 1, 1));
        do_j(50);

        step(pack5(4, 3, 4, 4, 4), 5'b0, mk(4, 0, 5'h1F, 5, 0, 0));
        step(pack5(4, 3, 4, 4, 4), 5'b0, mk(4, 0, 5'h1D, 4, 1, 0));
        do_j(4);

        step(pack5(7, 7, 7, 8, 9), 5'b0, mk(7, 0, 5'h1F, 5, 0, 0));
        step(pack5(7, 7, 7, 8, 9), 5'b0, mk(7, 0, 5'h07, 3, 1, 0));
        step(pack5(1, 2, 0, 55, 55), 5'b0, mk(0, 0, 5'h07, 3, 1, 0));
        step(pack5(1, 2, 0, 55, 55), 5'b0, mk(0, 0, 5'h07, 3, 1, 0));
        step(pack5(1, 2, 0, 55, 55), 5'b0, mk(0, 0, 5'h07, 3, 1, 0));
        step(pack5(1, 0, 0, 55, 55), 5'b0, mk(0, 0, 5'h06, 2, 1, 0));

        @(negedge clk);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.mod_sum  = pack5(33, 33, 33, 33, 33);
        bus.mod_cout = '0;
        @(negedge clk);
        chk("rst2_out_valid", bus.out_valid, 0);
        chk("rst2_sum", bus.sum, 0);
        chk("rst2_enable", bus.enable, 5'h1F);
        chk("rst2_active_count", bus.active_count, 5);
        chk("rst2_fault_flag", bus.fault_flag, 0);
        rst          = 1'b0;
        bus.in_valid = 1'b0;

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/self_purging_voter.md
SELF_PURGING_VOTER -- requirements
Module: self_purging_voter

Interface
REQ-001 Parameter: adder_width, 32, width of each redundant adder sum.
REQ-002 Parameter: N, 5, number of redundant adder replicas voted (3..8).
REQ-003 Parameter: LIMIT, 2, consecutive mismatching samples before a replica is purged (1..15).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 J  input  1  synchronous re-initialise of purge state; all replicas re-enabled.
REQ-007 in_valid  input  1  replica outputs valid this cycle.
REQ-008 mod_sum  input  N*adder_width  replica sums; replica i at bits [i*adder_width +: adder_width].
REQ-009 mod_cout  input  N  replica carry-outs; bit i = replica i.
REQ-010 out_valid  output  1  voted result valid.
REQ-011 sum  output  adder_width  voted sum.
REQ-012 cout  output  1  voted carry-out.
REQ-013 enable  output  N  replica-active mask; 1 = participating in vote.
REQ-014 active_count  output  4  number of 1s in enable.
REQ-015 fault_flag  output  1  sticky; set when any replica is purged.
REQ-016 tie_err  output  1  sticky; set when any voted bit had no majority.

Function
REQ-017 The voter SHALL treat {cout, sum} as one (adder_width+1)-bit word per replica.
REQ-018 Per bit, the voted value SHALL be 1 when ones among active replicas exceed active_count/2, 0 when zeros exceed it.
REQ-019 On an exact tie (even active_count), the bit SHALL be 0 and tie_err SHALL set.
REQ-020 Disabled replicas SHALL be ignored entirely by the vote and by mismatch tracking.
REQ-021 Latency SHALL be 1 cycle: sample with in_valid=1 at edge k gives out_valid=1 with sum/cout during cycle k+1; out_valid=0 otherwise; sum/cout hold last value when out_valid=0.
REQ-022 Each replica SHALL have a saturating mismatch counter, 4 bits.
REQ-023 On a valid sample, an active replica whose word differs from the voted word in any bit SHALL increment its counter; an agreeing replica's counter SHALL clear to 0.
REQ-024 Samples with in_valid=0 SHALL leave all counters unchanged.
REQ-025 When a counter reaches LIMIT, the replica's enable bit SHALL clear at that same edge and its counter SHALL clear.
REQ-026 Purging takes effect from the next sample; the sample that triggered the purge SHALL still be voted with the old mask.
REQ-027 Several replicas reaching LIMIT at the same edge SHALL be purged together.
REQ-028 A purge SHALL be suppressed if it would leave active_count below 2; the counters involved SHALL saturate at LIMIT and the mask SHALL stay unchanged.
REQ-029 Tie bits SHALL not count as a mismatch for any replica.
REQ-030 active_count SHALL track enable in the same cycle (registered together).
REQ-031 J=1 SHALL set enable to all ones, clear counters, fault_flag and tie_err, and force out_valid=0 for that edge; in_valid is ignored while J=1.

Reset
REQ-032 rst=1 SHALL set out_valid=0, sum=0, cout=0, enable=all ones, active_count=N, all counters=0, fault_flag=0, tie_err=0.
REQ-033 rst SHALL take priority over J and in_valid; asserting rst mid-operation discards any in-flight sample.

Verification (N=5, adder_width=32, LIMIT=2)
REQ-034 rst high 2 cycles -> out_valid=0, sum=0, cout=0, enable=5'b11111, active_count=5, flags 0.
REQ-035 All replicas sum=10, cout=0 with in_valid=1 -> next cycle out_valid=1, sum=10, cout=0, enable unchanged.
REQ-036 Replica 2 outputs 11, others 10, for two consecutive valid samples -> sum=10 both cycles; after second edge enable=5'b11011, active_count=4, fault_flag=1.
REQ-037 Replica 2 wrong once, correct next sample, wrong once again -> never purged, enable=5'b11111, fault_flag=0.
REQ-038 Mask purged to 5'b00011; replica0 sum=48, replica1 sum=49 -> sum=48, tie_err=1, enable stays 5'b00011.
REQ-039 Replica 1 purged, then J=1 one cycle -> enable=5'b11111, active_count=5, fault_flag=0, out_valid=0 that cycle.
